// File: rtl/t03_vga_pkg.sv
// Shared VGA timing source for the team_03 path: counter width, default
// geometry, comparator sync/window constants and the counter FSM states.
package t03_vga_pkg;

    localparam int CNT_W       = 11;
    localparam int H_TOTAL_DEF = 211;
    localparam int V_TOTAL_DEF = 640;
    localparam int DIV_DEF     = 5;

    // Comparator decode: hsync is low for Hcnt 0..HSYNC_END-1, vsync likewise.
    localparam int HSYNC_END   = 25;
    localparam int H_DISP_BEG  = 40;
    localparam int H_DISP_END  = 200;
    localparam int VSYNC_END   = 2;
    localparam int V_DISP_BEG  = 35;
    localparam int V_DISP_END  = 515;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } vga_state_e;

    function automatic logic [CNT_W-1:0] last_count(input int total);
        return CNT_W'(total - 1);
    endfunction

endpackage

// File: rtl/t03_tick_gen.sv
// Pixel-tick prescaler: divides enabled clk cycles by DIV and flags the
// last cycle of each group as the counter advance tick.
module t03_tick_gen #(
    parameter int DIV = 5
) (
    input  logic clk,
    input  logic nrst,
    input  logic en,
    input  logic clear,
    output logic tick
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    logic [DW-1:0] div_q;
    logic [DW-1:0] div_d;
    logic          last_s;

    assign last_s = (div_q == DIV_LAST);
    // Gated by nrst so a DIV=1 build cannot report a tick while held in reset.
    assign tick   = en && !clear && nrst && last_s;

    // Prescaler next state: clear wins, freeze while disabled.
    always_comb begin
        div_d = div_q;
        if (clear) begin
            div_d = '0;
        end else if (en) begin
            if (last_s) begin
                div_d = '0;
            end else begin
                div_d = div_q + DW'(1);
            end
        end else begin
            div_d = div_q;
        end
    end

    // Prescaler register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/t03_vga_counter.sv
// Horizontal/vertical position generator with run/restart control,
// line/frame strobes and a completed-frame counter.
module t03_vga_counter
    import t03_vga_pkg::*;
#(
    parameter int H_TOTAL = H_TOTAL_DEF,
    parameter int V_TOTAL = V_TOTAL_DEF,
    parameter int DIV     = DIV_DEF
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             en,
    input  logic             restart,
    output logic [CNT_W-1:0] Hcnt,
    output logic [CNT_W-1:0] Vcnt,
    output logic             tick,
    output logic             line_end,
    output logic             frame_end,
    output logic [7:0]       frame_cnt
);

    localparam logic [CNT_W-1:0] H_LAST = last_count(H_TOTAL);
    localparam logic [CNT_W-1:0] V_LAST = last_count(V_TOTAL);

    vga_state_e       state_q;
    vga_state_e       state_d;
    logic [CNT_W-1:0] hcnt_q;
    logic [CNT_W-1:0] hcnt_d;
    logic [CNT_W-1:0] vcnt_q;
    logic [CNT_W-1:0] vcnt_d;
    logic [7:0]       frame_q;
    logic [7:0]       frame_d;
    logic             tick_s;
    logic             h_last_s;
    logic             v_last_s;

    t03_tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk   (clk),
        .nrst  (nrst),
        .en    (en),
        .clear (restart),
        .tick  (tick_s)
    );

    assign h_last_s  = (hcnt_q == H_LAST);
    assign v_last_s  = (vcnt_q == V_LAST);
    assign tick      = tick_s;
    assign line_end  = tick_s && h_last_s;
    assign frame_end = tick_s && h_last_s && v_last_s;
    assign Hcnt      = hcnt_q;
    assign Vcnt      = vcnt_q;
    assign frame_cnt = frame_q;

    // Run-state next state; restart always returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN:     state_d = RUN;
            default: state_d = IDLE;
        endcase
        if (restart) begin
            state_d = IDLE;
        end else begin
            state_d = state_d;
        end
    end

    // Position and frame counters advance only on tick; wraps cascade H->V->frame.
    always_comb begin
        hcnt_d  = hcnt_q;
        vcnt_d  = vcnt_q;
        frame_d = frame_q;
        if (restart) begin
            hcnt_d  = '0;
            vcnt_d  = '0;
            frame_d = 8'd0;
        end else if (tick_s) begin
            if (h_last_s) begin
                hcnt_d = '0;
                if (v_last_s) begin
                    vcnt_d  = '0;
                    frame_d = frame_q + 8'd1;
                end else begin
                    vcnt_d = vcnt_q + CNT_W'(1);
                end
            end else begin
                hcnt_d = hcnt_q + CNT_W'(1);
            end
        end else begin
            hcnt_d = hcnt_q;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            frame_q <= 8'd0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            frame_q <= frame_d;
        end
    end

endmodule

// File: tb/tb_t03_vga_counter.sv
// Randomized scoreboard bench for t03_vga_counter on a small geometry so that
// line, frame and 255->0 frame_cnt wraps are all reached in a short run.
module tb_t03_vga_counter;

    localparam int H = 11;
    localparam int V = 4;
    localparam int D = 3;

    typedef struct {
        int h;
        int v;
        int f;
        int t;
        int le;
        int fe;
    } exp_t;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        en = 1'b0;
    logic        restart = 1'b0;
    logic [10:0] Hcnt;
    logic [10:0] Vcnt;
    logic        tick;
    logic        line_end;
    logic        frame_end;
    logic [7:0]  frame_cnt;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   en_cycles = 0;  // enabled cycles since the last clear
    int   cur_h = 0;

    t03_vga_counter #(
        .H_TOTAL (H),
        .V_TOTAL (V),
        .DIV     (D)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .en        (en),
        .restart   (restart),
        .Hcnt      (Hcnt),
        .Vcnt      (Vcnt),
        .tick      (tick),
        .line_end  (line_end),
        .frame_end (frame_end),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int expv);
        total = total + 1;
        if (act != expv) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Drive one cycle of inputs and push what the outputs must show during it.
    // Position is derived from the number of elapsed ticks, not from counters.
    task automatic drive(input logic n, input logic e, input logic r);
        exp_t x;
        int   ticks;
        @(negedge clk);
        nrst    = n;
        en      = e;
        restart = r;
        if (!n) en_cycles = 0;
        ticks = en_cycles / D;
        x.h  = ticks % H;
        x.v  = (ticks / H) % V;
        x.f  = (ticks / (H * V)) % 256;
        x.t  = 0;
        x.le = 0;
        x.fe = 0;
        if (n && !r && e) begin
            x.t  = ((en_cycles % D) == D - 1) ? 1 : 0;
            x.le = (x.t == 1 && x.h == H - 1) ? 1 : 0;
            x.fe = (x.le == 1 && x.v == V - 1) ? 1 : 0;
        end
        cur_h = x.h;
        exp_q.push_back(x);
        if (n && r) en_cycles = 0;
        else if (n && e) en_cycles = en_cycles + 1;
    endtask

    // Monitor: compare the DUT against the oldest expectation each cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("Hcnt", int'(Hcnt), e.h);
                chk("Vcnt", int'(Vcnt), e.v);
                chk("frame_cnt", int'(frame_cnt), e.f);
                chk("tick", int'(tick), e.t);
                chk("line_end", int'(line_end), e.le);
                chk("frame_end", int'(frame_end), e.fe);
            end
        end
    end

    initial begin
        int guard;
        // Reset held with en high.
        repeat (3) drive(1'b0, 1'b1, 1'b0);
        // Continuous run from reset: first tick at cycle D, several lines.
        repeat (60) drive(1'b1, 1'b1, 1'b0);
        // Random enable pauses and occasional restarts.
        for (int i = 0; i < 2000; i++) begin
            drive(1'b1, ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
        end
        // Restart and en together exactly on a tick cycle.
        guard = 0;
        while ((en_cycles % D) != D - 1 && guard < 20) begin
            drive(1'b1, 1'b1, 1'b0);
            guard++;
        end
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        // Mid-line asynchronous reset.
        guard = 0;
        while (cur_h != 5 && guard < 100) begin
            drive(1'b1, 1'b1, 1'b0);
            guard++;
        end
        chk("reach_mid_line", cur_h, 5);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        // Long run past 256 frames to cover the frame_cnt wrap.
        repeat (256 * H * V * D + 200) drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1);
        repeat (20) drive(1'b1, ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0, 1'b0);
        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        #5;
        chk("scoreboard_drain", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/t03_vga_counter.md
# t03_vga_counter

Free-running horizontal/vertical position generator for the team_03 VGA path. Produces the 11-bit `Hcnt`/`Vcnt` pair consumed by `t03_comparator` (sync and display-window decode). Counters advance on a programmable pixel-tick prescaler, with run/restart control and line/frame strobes for the framebuffer fetch logic.

## Interface
Parameters:
- `H_TOTAL`, 211: horizontal count period; `Hcnt` runs 0..H_TOTAL-1. Must be ≤ 2048.
- `V_TOTAL`, 640: vertical count period; `Vcnt` runs 0..V_TOTAL-1. Must be ≤ 2048.
- `DIV`, 5: clk cycles per count tick. DIV ≥ 1; DIV = 1 means a tick every cycle.

Ports:
- `clk`  in  1  system clock; the single clock domain.
- `nrst`  in  1  reset, asynchronous assert, active-low.
- `en`  in  1  run enable. While low, prescaler and counters hold.
- `restart`  in  1  synchronous clear of prescaler, counters and `frame_cnt`.
- `Hcnt`  out  11  horizontal position, registered.
- `Vcnt`  out  11  vertical position, registered.
- `tick`  out  1  one-cycle pulse in the cycle the counters advance.
- `line_end`  out  1  high with `tick` when `Hcnt == H_TOTAL-1`.
- `frame_end`  out  1  high with `tick` when `Hcnt == H_TOTAL-1` and `Vcnt == V_TOTAL-1`.
- `frame_cnt`  out  8  completed-frame count, wraps 255→0.

## Operation
- State machine: IDLE (after reset or `restart`, before the first `en`) and RUN. IDLE→RUN on `en`=1. RUN stays in RUN when `en` drops, holding counters. `restart` forces IDLE from either state.
- Prescaler `div_cnt` counts 0..DIV-1 while `en`=1 in RUN (and on the IDLE→RUN cycle). `tick` = `en && div_cnt == DIV-1`.
- On `tick`:
  - `Hcnt` increments.
  - At H_TOTAL-1, `Hcnt` wraps to 0 and `Vcnt` increments.
  - At V_TOTAL-1 with the H wrap, `Vcnt` wraps to 0 and `frame_cnt` increments.
- `line_end` and `frame_end` are combinational from the current counter values ANDed with `tick`. They describe the wrap occurring at the next edge.
- `restart` has priority over `en`. If both are high, the clear wins and no tick is issued that cycle.
- Width rule: counters are 11-bit unsigned. Compare against `H_TOTAL-1`/`V_TOTAL-1` cast to 11 bits. No value ≥ H_TOTAL/V_TOTAL is ever output.

## Timing
- Reset (`nrst`=0, any time): `Hcnt`=0, `Vcnt`=0, `frame_cnt`=0, `div_cnt`=0, state IDLE, `tick`=`line_end`=`frame_end`=0. Reset mid-line discards the position; there is no partial-frame recovery.
- First tick comes DIV cycles after `en` rises. `Hcnt` becomes 1 on the edge ending that tick cycle.
- Counter latency: 1 clk from `tick` to updated `Hcnt`/`Vcnt`.
- Period: H_TOTAL·DIV clk per line; H_TOTAL·V_TOTAL·DIV clk per frame.
- `en` low mid-count: `div_cnt` freezes. Resuming continues the same phase, so there is no extra or lost tick.
- `restart` clears on the next edge. The cycle after, outputs are all zero.

## Structure
- `t03_vga_pkg`: default H_TOTAL/V_TOTAL/DIV constants, `CNT_W`=11, and `typedef enum logic {IDLE, RUN}`. The comparator's sync/window constants move into this package so both blocks share one timing source.
- One natural sub-module: `t03_tick_gen`, the DIV prescaler with `en`/`clear` producing `tick`. The top holds the FSM and the H/V/frame counters.

## Test plan
- Reset: hold `nrst`=0 with `en`=1 → all outputs 0. Assert `nrst` low asynchronously mid-line (`Hcnt`=100) → outputs 0 before the next edge.
- Basic count, DIV=5: `en`=1 from reset → first `tick` at cycle 5. `Hcnt` reads 1 after it, and 10 after 50 clk.
- Line wrap: run to `Hcnt`=210 → `line_end`=1 with `tick`, then `Hcnt`=0 and `Vcnt` incremented.
- Frame wrap: run to `Hcnt`=210, `Vcnt`=639 → `frame_end`=1, then both 0 and `frame_cnt` 0→1. Preload via a small-parameter build (H_TOTAL=4, V_TOTAL=3, DIV=1) to hit the 255→0 `frame_cnt` wrap.
- Pause: drop `en` for 7 cycles at `div_cnt`=2 → no tick and counters frozen. After resume, the next tick comes 2 clk later.
- Priority: `restart`=`en`=1 at `Hcnt`=57 → no tick, next cycle all counters 0, state IDLE. With DIV=1, the comparator-facing sequence gives hsync low for `Hcnt` 0..24 each line.
